// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant,
// per-owner hold limit with preemption, and per-requester mask.
module rr_arbiter_n #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int CW      = $clog2(HOLD_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic          preempt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [CW-1:0] hold_cnt, hold_n;
    logic [IW-1:0] idx_n;
    logic          valid_n;
    logic          pre_n;
    logic [N-1:0]  grant_n;

    logic [N-1:0]  eff_req;
    logic          own_req;
    logic          oth_req;
    logic          at_max;
    logic [IW-1:0] nxt;
    logic [IW-1:0] win_ptr;
    logic [IW-1:0] win_nxt;

    // First set bit of r at s, s+1, ... wrapping modulo N.
    function automatic logic [IW-1:0] pick(
        input logic [N-1:0]  r,
        input logic [IW-1:0] s
    );
        logic [2*N-1:0] dbl;
        logic [IW-1:0]  w;
        logic           f;
        int             t;
        dbl = {r, r} >> s;
        w   = '0;
        f   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!f && dbl[i]) begin
                f = 1'b1;
                t = int'(s) + i;
                if (t >= N) t = t - N;
                w = IW'(t);
            end
        end
        return w;
    endfunction

    assign eff_req = req & ~mask;
    assign own_req = |(eff_req & grant);
    assign oth_req = |(eff_req & ~grant);
    assign at_max  = (hold_cnt == CW'(HOLD_MAX));
    assign nxt     = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    assign win_ptr = pick(eff_req, ptr);
    assign win_nxt = pick(eff_req, nxt);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        idx_n   = grant_idx;
        valid_n = grant_valid;
        pre_n   = 1'b0;
        case (state)
            IDLE: begin
                if (|eff_req) begin
                    state_n = GRANT;
                    idx_n   = win_ptr;
                    valid_n = 1'b1;
                    hold_n  = CW'(1);
                end
            end
            GRANT: begin
                if (!own_req) begin
                    ptr_n = nxt;
                    if (oth_req) begin
                        idx_n  = win_nxt;
                        hold_n = CW'(1);
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                        valid_n = 1'b0;
                        hold_n  = '0;
                    end
                end else if (at_max && oth_req) begin
                    ptr_n  = nxt;
                    idx_n  = win_nxt;
                    hold_n = CW'(1);
                    pre_n  = 1'b1;
                end else if (!at_max) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                valid_n = 1'b0;
                hold_n  = '0;
            end
        endcase
        grant_n = valid_n ? (N'(1) << idx_n) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            hold_cnt    <= hold_n;
            grant       <= grant_n;
            grant_valid <= valid_n;
            grant_idx   <= idx_n;
            preempt     <= pre_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed vector bench for rr_arbiter_n (N=4, HOLD_MAX=8).
module tb_rr_arbiter_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       preempt;

    int n_chk  = 0;
    int n_fail = 0;

    rr_arbiter_n #(.N(4), .HOLD_MAX(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .preempt     (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] mask;
        logic [3:0] grant;
        logic       pre;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] rq,
                       input logic [3:0] mk, input logic [3:0] g,
                       input logic p, input int n);
        vec_t v;
        v.rst = r; v.req = rq; v.mask = mk; v.grant = g; v.pre = p;
        repeat (n) vq.push_back(v);
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        if (g[1]) r = 2'd1;
        if (g[2]) r = 2'd2;
        if (g[3]) r = 2'd3;
        return r;
    endfunction

    initial begin
        logic [7:0] act, exp;
        int cyc, pre_cnt;
        rst  = 1'b1;
        req  = 4'b0000;
        mask = 4'b0000;

        // reset state
        add(1, 4'b0000, 4'b0000, 4'b0000, 0, 2);
        // hold limit preempts 0 -> 2 -> 0
        add(0, 4'b0101, 4'b0000, 4'b0001, 0, 8);
        add(0, 4'b0101, 4'b0000, 4'b0100, 1, 1);
        add(0, 4'b0101, 4'b0000, 4'b0100, 0, 7);
        add(0, 4'b0101, 4'b0000, 4'b0001, 1, 1);
        // lone requester saturates, never preempted
        add(0, 4'b0001, 4'b0000, 4'b0001, 0, 20);
        // owner release hands over with no bubble
        add(0, 4'b1010, 4'b0000, 4'b0010, 0, 3);
        add(0, 4'b1000, 4'b0000, 4'b1000, 0, 1);
        // masking the owner moves grant, search from 3 wraps to 0
        add(0, 4'b0100, 4'b0000, 4'b0100, 0, 2);
        add(0, 4'b0101, 4'b0100, 4'b0001, 0, 1);
        add(0, 4'b0100, 4'b0000, 4'b0100, 0, 1);
        add(0, 4'b0100, 4'b0100, 4'b0000, 0, 2);
        // idle search starts from ptr=3
        add(0, 4'b1111, 4'b0000, 4'b1000, 0, 1);
        // reset mid-grant, then rotation 0,1,2,3,0
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 8);
        add(0, 4'b1111, 4'b0000, 4'b0010, 1, 1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 0, 7);
        add(0, 4'b1111, 4'b0000, 4'b0100, 1, 1);
        add(0, 4'b1111, 4'b0000, 4'b0100, 0, 7);
        add(0, 4'b1111, 4'b0000, 4'b1000, 1, 1);
        add(0, 4'b1111, 4'b0000, 4'b1000, 0, 7);
        add(0, 4'b1111, 4'b0000, 4'b0001, 1, 1);
        // masked contender does not trigger preemption
        add(0, 4'b0011, 4'b0010, 4'b0001, 0, 12);
        add(0, 4'b0011, 4'b0000, 4'b0010, 1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 2);

        foreach (vq[i]) begin
            @(negedge clk);
            rst  = vq[i].rst;
            req  = vq[i].req;
            mask = vq[i].mask;
            @(posedge clk);
            #1;
            act = {grant, grant_valid, grant_idx, preempt};
            exp = {vq[i].grant, |vq[i].grant, idx_of(vq[i].grant),
                   vq[i].pre};
            n_chk++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec %0d: got g=%b v=%b i=%0d p=%b, want g=%b v=%b i=%0d p=%b",
                         i, grant, grant_valid, grant_idx, preempt,
                         vq[i].grant, |vq[i].grant, idx_of(vq[i].grant),
                         vq[i].pre);
            end
        end

        // fairness: requester 3 waits at most (N-1)*HOLD_MAX+1 cycles
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        pre_cnt = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (preempt) pre_cnt++;
            if (grant[3]) break;
        end
        n_chk++;
        if (cyc != 25) begin
            n_fail++;
            $display("FAIL fair_wait: got %0d cycles, want 25", cyc);
        end
        n_chk++;
        if (pre_cnt != 3) begin
            n_fail++;
            $display("FAIL fair_preempts: got %0d, want 3", pre_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
